// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: shared constants and arbiter state encoding for the USB FS endpoint arbiters
package usb_fs_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  localparam int MAX_EPS = 16;
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_GRANTED = 1'b1;
endpackage

// File: rtl/usb_fs_ep_arb_if.sv
// usb_fs_ep_arb_if: endpoint request/grant/data bundle between endpoints, protocol engine and arbiter
interface usb_fs_ep_arb_if #(parameter int NUM_EPS = 4, parameter int DATA_W = 8);
  logic [NUM_EPS-1:0] ep_req;
  logic [NUM_EPS-1:0] ep_grant;
  logic [NUM_EPS*DATA_W-1:0] ep_data;
  logic [DATA_W-1:0] arb_data;
  logic arb_valid;
  logic [3:0] arb_idx;
  logic pe_busy;
  modport master(output ep_req, ep_data, pe_busy, input ep_grant, arb_data, arb_valid, arb_idx);
  modport slave(input ep_req, ep_data, pe_busy, output ep_grant, arb_data, arb_valid, arb_idx);
endinterface

// File: rtl/usb_fs_arb_pick.sv
// usb_fs_arb_pick: combinational winner picker, fixed priority or round-robin after start
module usb_fs_arb_pick #(parameter int N = 4) (
  input  logic [N-1:0] req,
  input  logic [3:0]   start,
  input  logic         mode,
  output logic [3:0]   idx,
  output logic         found
);
  logic [15:0] req16;
  logic [4:0] c;
  assign req16 = 16'(req);
  // wrap at N rather than 16 so non-power-of-two endpoint counts rotate correctly
  always_comb begin
    idx = '0;
    found = 1'b0;
    c = '0;
    for (int k = 0; k < N; k++) begin
      c = mode ? 5'(start) + 5'(k) + 5'd1 : 5'(k);
      c = (c >= 5'(N)) ? c - 5'(N) : c;
      if (!found && req16[c[3:0]]) begin
        found = 1'b1;
        idx = c[3:0];
      end
    end
  end
endmodule

// File: rtl/usb_fs_ep_arb.sv
// usb_fs_ep_arb: registered endpoint arbiter holding a grant while req or pe_busy is high
module usb_fs_ep_arb import usb_fs_pkg::*; #(
  parameter int NUM_EPS = 4,
  parameter int DATA_W = 8,
  parameter int ARB_MODE = ARB_RR
) (
  input logic clk,
  input logic reset_n,
  usb_fs_ep_arb_if.slave bus
);
  logic [0:0] state;
  logic [3:0] last_idx, win, idx;
  logic found;
  logic [NUM_EPS-1:0] grant;
  logic [15:0] req16;
  logic [DATA_W-1:0] slice [MAX_EPS];
  assign req16 = 16'(bus.ep_req);
  usb_fs_arb_pick #(.N(NUM_EPS)) u_pick (
    .req(bus.ep_req),
    .start(last_idx),
    .mode(ARB_MODE == ARB_RR),
    .idx(win),
    .found(found)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      grant <= '0;
      idx <= '0;
      last_idx <= 4'(NUM_EPS - 1);
    end else if (state == ARB_IDLE) begin
      if (!bus.pe_busy && found) begin
        state <= ARB_GRANTED;
        grant <= NUM_EPS'(1 << win);
        idx <= win;
        last_idx <= win;
      end
    end else if (!req16[idx] && !bus.pe_busy) begin
      state <= ARB_IDLE;
      grant <= '0;
    end
  end
  always_comb begin
    for (int i = 0; i < MAX_EPS; i++) slice[i] = '0;
    for (int i = 0; i < NUM_EPS; i++) slice[i] = bus.ep_data[i*DATA_W +: DATA_W];
  end
  assign bus.ep_grant = grant;
  assign bus.arb_idx = idx;
  assign bus.arb_valid = |grant;
  assign bus.arb_data = |grant ? slice[idx] : '0;
endmodule

// File: tb/tb_usb_fs_ep_arb.sv
// tb_usb_fs_ep_arb: directed checks of RR/fixed arbitration, busy hold, data mux, async reset and wrap
module tb_usb_fs_ep_arb;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int failures = 0;
  logic [7:0] data_tab [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  int seq [5] = '{0, 1, 2, 3, 0};
  always #5 clk = ~clk;

  usb_fs_ep_arb_if #(.NUM_EPS(4), .DATA_W(8)) a ();
  usb_fs_ep_arb_if #(.NUM_EPS(4), .DATA_W(8)) b ();
  usb_fs_ep_arb_if #(.NUM_EPS(16), .DATA_W(8)) c ();
  usb_fs_ep_arb_if #(.NUM_EPS(1), .DATA_W(8)) d ();

  usb_fs_ep_arb #(.NUM_EPS(4), .DATA_W(8), .ARB_MODE(1)) dut_rr (.clk(clk), .reset_n(reset_n), .bus(a));
  usb_fs_ep_arb #(.NUM_EPS(4), .DATA_W(8), .ARB_MODE(0)) dut_fx (.clk(clk), .reset_n(reset_n), .bus(b));
  usb_fs_ep_arb #(.NUM_EPS(16), .DATA_W(8), .ARB_MODE(1)) dut_16 (.clk(clk), .reset_n(reset_n), .bus(c));
  usb_fs_ep_arb #(.NUM_EPS(1), .DATA_W(8), .ARB_MODE(1)) dut_1 (.clk(clk), .reset_n(reset_n), .bus(d));

  always @(negedge clk) begin
    assert ($onehot0(a.ep_grant) && $onehot0(b.ep_grant) && $onehot0(c.ep_grant))
    else begin
      failures++;
      $error("FAIL onehot a=%b b=%b c=%b", a.ep_grant, b.ep_grant, c.ep_grant);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    a.ep_req = '0; a.pe_busy = 1'b0; a.ep_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    b.ep_req = '0; b.pe_busy = 1'b0; b.ep_data = '0;
    c.ep_req = '0; c.pe_busy = 1'b0; c.ep_data = '0;
    d.ep_req = '0; d.pe_busy = 1'b0; d.ep_data = 8'h77;
    repeat (2) tick();
    check("rst_grant", a.ep_grant, 0);
    check("rst_valid", a.arb_valid, 0);
    check("rst_idx", a.arb_idx, 0);
    check("rst_data", a.arb_data, 0);
    reset_n = 1'b1;
    a.ep_req = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", a.ep_grant, 32'(1 << seq[k]));
      check("rr_idx", a.arb_idx, seq[k]);
      check("rr_data", a.arb_data, data_tab[seq[k]]);
      a.ep_req[seq[k]] = 1'b0;
      tick();
      check("rr_dead_grant", a.ep_grant, 0);
      check("rr_dead_valid", a.arb_valid, 0);
      check("rr_dead_data", a.arb_data, 0);
      a.ep_req = 4'hF;
      tick();
    end
    check("hold_ep1", a.ep_grant, 4'b0010);
    a.ep_data[15:8] = 8'h5A;
    #1 check("data_comb", a.arb_data, 8'h5A);
    a.ep_data[15:8] = 8'hBB;
    a.ep_req = 4'b0100;
    tick();
    check("rel_ep1", a.ep_grant, 0);
    tick();
    check("grant_ep2", a.ep_grant, 4'b0100);
    a.ep_req = 4'b0000;
    a.pe_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("busy_hold", a.ep_grant, 4'b0100);
    end
    a.pe_busy = 1'b0;
    tick();
    check("busy_release", a.ep_grant, 0);
    a.ep_req = 4'hF;
    a.pe_busy = 1'b1;
    tick();
    check("idle_busy_block", a.ep_grant, 0);
    a.pe_busy = 1'b0;
    tick();
    check("rr_after_ep2", a.ep_grant, 4'b1000);
    check("rr_after_ep2_idx", a.arb_idx, 3);

    b.ep_req = 4'b1010;
    tick();
    check("fx_grant1", b.ep_grant, 4'b0010);
    check("fx_idx1", b.arb_idx, 1);
    b.ep_req = 4'b1000;
    tick();
    check("fx_dead", b.ep_grant, 0);
    tick();
    check("fx_grant3", b.ep_grant, 4'b1000);
    check("fx_idx3", b.arb_idx, 3);
    b.ep_req = 4'b1001;
    tick();
    check("fx_ignore_other", b.ep_grant, 4'b1000);
    b.ep_req = 4'b0001;
    tick();
    check("fx_dead2", b.ep_grant, 0);
    tick();
    check("fx_grant0", b.ep_grant, 4'b0001);
    b.ep_req = '0;
    tick();

    c.ep_req = 16'h8001;
    tick();
    check("w16_ep0", c.ep_grant, 16'h0001);
    c.ep_req = 16'h8000;
    tick();
    check("w16_dead", c.ep_grant, 0);
    c.ep_req = 16'h8001;
    tick();
    check("w16_ep15", c.ep_grant, 16'h8000);
    check("w16_idx15", c.arb_idx, 15);
    c.ep_req = 16'h0001;
    tick();
    check("w16_dead2", c.ep_grant, 0);
    c.ep_req = 16'h8001;
    tick();
    check("w16_wrap_ep0", c.ep_grant, 16'h0001);
    check("w16_wrap_idx", c.arb_idx, 0);

    d.ep_req = 1'b1;
    tick();
    check("n1_grant", d.ep_grant, 1);
    check("n1_data", d.arb_data, 8'h77);
    d.ep_req = 1'b0;
    tick();
    check("n1_dead", d.ep_grant, 0);
    d.ep_req = 1'b1;
    tick();
    check("n1_regrant", d.ep_grant, 1);

    #2 reset_n = 1'b0;
    #1;
    check("async_grant", a.ep_grant, 0);
    check("async_valid", a.arb_valid, 0);
    check("async_idx", a.arb_idx, 0);
    check("async_data", a.arb_data, 0);
    check("async_c", c.ep_grant, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_ep0", a.ep_grant, 4'b0001);
    check("post_rst_idx", a.arb_idx, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_fs_ep_arb.md
Name: usb_fs_ep_arb

Overview:
Parametrised, registered endpoint arbiter that replaces the purely combinational fixed-priority in/out arbiters in front of the USB FS protocol engines. It grants one endpoint of NUM_EPS at a time, in either fixed-priority or round-robin mode. A granted endpoint keeps its grant while it holds req or while the protocol engine reports a transaction in progress. The granted endpoint's data byte is muxed to the engine. One instance serves IN endpoints (DATA_W=8); another serves OUT endpoints (data port unused).

Parameters:
NUM_EPS, 4, number of endpoints arbitrated; legal range 1..16.
DATA_W, 8, width of each endpoint data slice.
ARB_MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin starting after the last granted index.

Ports:
clk  input  1  system clock; all state on rising edge.
reset_n  input  1  asynchronous, active-low reset; clears all state immediately, released synchronously by the integrator.
ep_req  input  NUM_EPS  per-endpoint request, level.
ep_grant  output  NUM_EPS  one-hot or zero grant, registered.
ep_data  input  NUM_EPS*DATA_W  packed endpoint data; slice i = bits [i*DATA_W +: DATA_W].
arb_data  output  DATA_W  data slice of the granted endpoint; zero when no grant.
arb_valid  output  1  high while any grant is held (equals OR of ep_grant).
arb_idx  output  4  index of the granted endpoint; holds the last value when no grant.
pe_busy  input  1  protocol engine mid-transaction; blocks grant release and re-arbitration.

Behaviour:
- Reset values: ep_grant=0, arb_valid=0, arb_idx=0, arb_data=0, FSM=IDLE.
- Round-robin pointer last_idx resets to NUM_EPS-1, so ep0 has first priority after reset.
- FSM has two states, IDLE and GRANTED.
- IDLE:
  - If pe_busy=0 and |ep_req, pick a winner and go to GRANTED at the next edge, with ep_grant[w]=1, arb_idx=w, last_idx=w.
  - Latency from req to grant is 1 cycle.
  - If pe_busy=1, stay in IDLE and issue no grant.
- Winner selection:
  - ARB_MODE=0: lowest set index of ep_req.
  - ARB_MODE=1: first set index scanning last_idx+1, last_idx+2, ... modulo NUM_EPS, wrapping past NUM_EPS-1 to 0.
  - The pointer arithmetic is 4-bit with explicit wrap at NUM_EPS, not at 16.
- GRANTED:
  - Hold the grant while ep_req[arb_idx]=1 or pe_busy=1.
  - When both are 0, go to IDLE at the next edge with ep_grant=0.
  - There is exactly one dead cycle between grants. The earliest new grant is 2 edges after the holder drops req, provided pe_busy=0.
- Requests from other endpoints during GRANTED are ignored. They are not queued; they are simply still asserted when IDLE evaluates.
- Req drop while pe_busy=1: the grant persists until pe_busy falls, then releases at the next edge.
- Req re-asserted by the holder in the release cycle: it competes normally in IDLE. In RR mode it has the lowest priority.
- arb_data is a combinational mux of ep_data by arb_idx, gated by arb_valid. There is no added latency from ep_data.
- NUM_EPS=1: the RR pointer is constant 0 and behaviour is identical in both modes.
- Reset asserted mid-grant: all outputs drop to reset values asynchronously.
- Invariant: ep_grant is never more than one-hot (assertion required in the bench).

Decomposition:
- Shared package usb_fs_pkg holds:
  - ARB_FIXED=0 and ARB_RR=1 constants;
  - a MAX_EPS=16 constant;
  - the 1-bit arbiter state encoding (ARB_IDLE, ARB_GRANTED).
- One natural sub-module, usb_fs_arb_pick: a combinational picker.
  - Inputs: req vector, start index, mode.
  - Outputs: winner index and found flag.
  - It is instantiated once and reused by any future OUT/IN arbiter variant.

Test Plan:
1. Reset, NUM_EPS=4, RR, ep_req=4'b1111 held -> grants ep0, then after each release (holder drops req for 1 cycle) the order is ep1, ep2, ep3, ep0; 1 dead cycle between grants.
2. ARB_MODE=0, ep_req=4'b1010 -> ep_grant=4'b0010, arb_idx=1 one cycle after req; after ep1 releases with req still 4'b1000 -> ep_grant=4'b1000.
3. Grant ep2, then ep_req[2]=0 while pe_busy=1 for 5 cycles -> ep_grant stays 4'b0100 for those 5 cycles; it clears on the edge after pe_busy falls.
4. ep_data={8'hDD,8'hCC,8'hBB,8'hAA}, grant ep1 -> arb_data=8'hBB in the same cycle; no grant -> arb_data=8'h00, arb_valid=0.
5. reset_n pulsed low mid-grant between clock edges -> ep_grant=0 and arb_valid=0 immediately, with no clock edge; after release, first grant goes to ep0 in RR.
6. NUM_EPS=16, RR, only ep_req[15] and ep_req[0] set, last_idx=15 -> ep0 is granted (wrap), then ep15.
